// File: rtl/cam_frame_writer_pkg.sv
// Shared constants, state encoding and the RGB565 -> RGB444 helper for the
// camera frame writer.
package cam_frame_writer_pkg;

    localparam int IMG_W  = 120;
    localparam int IMG_H  = 120;
    localparam int SRC_W  = 640;
    localparam int ADDR_W = 14;
    localparam int COL_W  = 10;
    localparam int ROW_W  = 7;

    localparam logic [COL_W-1:0]  COL_LIM   = COL_W'(IMG_W);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(SRC_W);
    localparam logic [ROW_W-1:0]  ROW_LIM   = ROW_W'(IMG_H);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(IMG_W);

    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        CAPT = 2'd2
    } state_t;

    function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

endpackage

// File: rtl/cam_frame_writer_luma.sv
// Two-stage luma pipeline: weighted 16-bit sum of the 8-bit expanded
// channels, then Y = sum[15:8]. Y holds its value between valid pixels.
module rgb565_to_luma
    import cam_frame_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_pix,
    output logic        out_valid,
    output logic [7:0]  y
);

    logic [7:0]  r8, g8, b8;
    logic [15:0] sum_d, sum_q;
    logic        sum_vld_d, sum_vld_q;
    logic [7:0]  y_d, y_q;
    logic        y_vld_d, y_vld_q;

    always_comb begin
        r8 = {in_pix[15:11], in_pix[15:13]};
        g8 = {in_pix[10:5], in_pix[10:9]};
        b8 = {in_pix[4:0], in_pix[4:2]};
        // Coefficients sum to 256, so the 16-bit sum cannot overflow.
        sum_d     = LUMA_R * {8'd0, r8} + LUMA_G * {8'd0, g8} + LUMA_B * {8'd0, b8};
        sum_vld_d = in_valid;
        y_d       = sum_vld_q ? sum_q[15:8] : y_q;
        y_vld_d   = sum_vld_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= 16'd0;
            sum_vld_q <= 1'b0;
            y_q       <= 8'd0;
            y_vld_q   <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            y_q       <= y_d;
            y_vld_q   <= y_vld_d;
        end
    end

    assign out_valid = y_vld_q;
    assign y         = y_q;

endmodule

// File: rtl/cam_frame_writer.sv
// Camera write side: pairs RGB565 bytes, crops to the top-left IMG_W x IMG_H
// pixels and emits buffer writes carrying RGB444 and 4-bit gray data.
module cam_frame_writer
    import cam_frame_writer_pkg::*;
(
    input  logic              clk_50,
    input  logic              rst,
    input  logic              capture,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_byte_valid,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data_rgb,
    output logic [3:0]        wr_data_gray,
    output logic [7:0]        gray_value,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        dbg_state
);

    // Write port is valid-only: the buffer accepts a write in every cycle
    // wr_en is high; wr_addr/wr_data_*/gray_value qualify that same cycle.

    state_t             state_d, state_q;
    logic               vsync_q, href_q;
    logic               phase_d, phase_q;
    logic [7:0]         hi_d, hi_q;
    logic [COL_W-1:0]   col_d, col_q;
    logic [ROW_W-1:0]   row_d, row_q;
    logic [ADDR_W-1:0]  base_d, base_q;
    logic               full_d, full_q;
    logic               s1_vld_d, s1_vld_q;
    logic [15:0]        s1_pix_d, s1_pix_q;
    logic [ADDR_W-1:0]  s1_addr_d, s1_addr_q;
    logic               s2_vld_d, s2_vld_q;
    logic [11:0]        s2_rgb_d, s2_rgb_q;
    logic [ADDR_W-1:0]  s2_addr_d, s2_addr_q;
    logic [11:0]        wr_rgb_d, wr_rgb_q;
    logic [ADDR_W-1:0]  wr_addr_d, wr_addr_q;
    logic               frame_done_d, frame_done_q;
    logic               frame_err_d, frame_err_q;

    logic vsync_rise, vsync_fall, href_fall, byte_ok, pix_done, keep, last_px;

    always_comb begin
        vsync_rise = cam_vsync & ~vsync_q;
        vsync_fall = ~cam_vsync & vsync_q;
        href_fall  = ~cam_href & href_q;
        // A byte in the href-fall detect cycle still belongs to the ending line.
        byte_ok    = cam_byte_valid & (cam_href | href_q);
        pix_done   = (state_q == CAPT) & byte_ok & phase_q;
        keep       = pix_done & (col_q < COL_LIM) & (row_q < ROW_LIM);
        last_px    = keep & (row_q == ROW_LAST) & (col_q == COL_LAST);

        state_d      = state_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        col_d        = col_q;
        row_d        = row_q;
        base_d       = base_q;
        full_d       = full_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        s1_vld_d  = keep;
        s1_pix_d  = keep ? {hi_q, cam_data} : s1_pix_q;
        s1_addr_d = keep ? base_q + ADDR_W'(col_q) : s1_addr_q;
        s2_vld_d  = s1_vld_q;
        s2_rgb_d  = s1_vld_q ? rgb565_to_444(s1_pix_q) : s2_rgb_q;
        s2_addr_d = s1_vld_q ? s1_addr_q : s2_addr_q;
        wr_rgb_d  = s2_vld_q ? s2_rgb_q : wr_rgb_q;
        wr_addr_d = s2_vld_q ? s2_addr_q : wr_addr_q;

        case (state_q)
            IDLE: begin
                if (capture && cam_vsync) state_d = SYNC;
            end
            SYNC: begin
                if (vsync_fall) begin
                    state_d = CAPT;
                    phase_d = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = '0;
                    full_d  = 1'b0;
                end
            end
            CAPT: begin
                if (byte_ok) begin
                    if (!phase_q) begin
                        hi_d    = cam_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q != COL_MAX) col_d = col_q + 10'd1;
                    end
                end
                if (href_fall) begin
                    phase_d = 1'b0;
                    col_d   = '0;
                    if (row_q != ROW_LIM) begin
                        row_d  = row_q + 7'd1;
                        base_d = base_q + BASE_STEP;
                    end
                end
                if (last_px || row_d == ROW_LIM) full_d = 1'b1;
                // Once full, wait for the pixel pipeline to drain so frame_done
                // lands the cycle after the final write.
                if (full_q) begin
                    if (!s1_vld_q && !s2_vld_q) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end else if (vsync_rise && !full_d) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= 8'd0;
            col_q        <= '0;
            row_q        <= '0;
            base_q       <= '0;
            full_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_pix_q     <= 16'd0;
            s1_addr_q    <= '0;
            s2_vld_q     <= 1'b0;
            s2_rgb_q     <= 12'd0;
            s2_addr_q    <= '0;
            wr_rgb_q     <= 12'd0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= cam_vsync;
            href_q       <= cam_href;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            col_q        <= col_d;
            row_q        <= row_d;
            base_q       <= base_d;
            full_q       <= full_d;
            s1_vld_q     <= s1_vld_d;
            s1_pix_q     <= s1_pix_d;
            s1_addr_q    <= s1_addr_d;
            s2_vld_q     <= s2_vld_d;
            s2_rgb_q     <= s2_rgb_d;
            s2_addr_q    <= s2_addr_d;
            wr_rgb_q     <= wr_rgb_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    rgb565_to_luma u_luma (
        .clk       (clk_50),
        .rst       (rst),
        .in_valid  (s1_vld_q),
        .in_pix    (s1_pix_q),
        .out_valid (wr_en),
        .y         (gray_value)
    );

    assign wr_addr      = wr_addr_q;
    assign wr_data_rgb  = wr_rgb_q;
    assign wr_data_gray = gray_value[7:4];
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer: drives byte-level camera frames and
// checks every buffer write against hand-computed pixel values.
module tb_cam_frame_writer;

    logic        clk_50 = 1'b0;
    logic        rst;
    logic        capture;
    logic        cam_vsync;
    logic        cam_href;
    logic        cam_byte_valid;
    logic [7:0]  cam_data;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [11:0] wr_data_rgb;
    logic [3:0]  wr_data_gray;
    logic [7:0]  gray_value;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int done_cyc = 0;
    int lat_drv = 0;

    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];
    int          obs_cyc[$];

    cam_frame_writer dut (
        .clk_50         (clk_50),
        .rst            (rst),
        .capture        (capture),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_byte_valid (cam_byte_valid),
        .cam_data       (cam_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data_rgb    (wr_data_rgb),
        .wr_data_gray   (wr_data_gray),
        .gray_value     (gray_value),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .dbg_state      (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle
    always @(negedge clk_50) begin
        if (wr_en) begin
            obs_q.push_back({wr_addr, wr_data_rgb, wr_data_gray, gray_value});
            obs_cyc.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed RGB444 and luma for each colour used in the stimulus
    function automatic logic [37:0] exp_word(input int addr, input logic [15:0] px);
        logic [11:0] rgb;
        logic [7:0]  y;
        case (px)
            16'hFFFF: begin rgb = 12'hFFF; y = 8'hFF; end
            16'h07E0: begin rgb = 12'h0F0; y = 8'h95; end
            16'h001F: begin rgb = 12'h00F; y = 8'h1C; end
            default:  begin rgb = 12'hF00; y = 8'h4C; end
        endcase
        return {14'(addr), rgb, y[7:4], y};
    endfunction

    function automatic logic [15:0] pix_of(input int kind, input int row, input int col);
        if (kind == 1) return 16'h07E0;
        if (kind == 2) return 16'h001F;
        if (row == 1 && col == 0) return 16'hFFFF;
        return 16'hF800;
    endfunction

    task automatic send_line(input int row, input int npix, input int kind,
                             input bit odd, input bit expect_wr);
        logic [15:0] px;
        cam_href = 1'b1;
        for (int c = 0; c < npix; c++) begin
            px = pix_of(kind, row, c);
            cam_byte_valid = 1'b1;
            cam_data = px[15:8];
            tick();
            cam_data = px[7:0];
            if (kind == 0 && row == 1 && c == 0) lat_drv = cyc;
            tick();
            if (expect_wr && row < 120 && c < 120)
                exp_q.push_back(exp_word(row * 120 + c, px));
        end
        if (odd) begin
            cam_data = 8'hAA;
            tick();
        end
        cam_byte_valid = 1'b0;
        cam_href = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_frame(input int nlines, input int npix, input int kind,
                              input bit expect_wr, input int odd_row, input int cap_off_row);
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < nlines; r++) begin
            if (r == cap_off_row) capture = 1'b0;
            send_line(r, (r == odd_row) ? 120 : npix, kind, r == odd_row, expect_wr);
        end
        cam_vsync = 1'b1;
        repeat (8) tick();
    endtask

    task automatic check_writes(input string tag, input int base, input int exp_n);
        int bad;
        chk({tag, "_count"}, obs_q.size() - base, exp_n);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= obs_q.size() || obs_q[base + i] !== exp_q[i]) bad++;
        chk({tag, "_data_bad"}, bad, 0);
        exp_q.delete();
    endtask

    initial begin
        int base;
        int d0;
        int e0;
        int b0;
        int last_wr;

        rst = 1'b1;
        capture = 1'b0;
        cam_vsync = 1'b1;
        cam_href = 1'b0;
        cam_byte_valid = 1'b0;
        cam_data = 8'd0;
        repeat (3) tick();
        chk("reset_outputs", {wr_en, wr_addr, wr_data_rgb, wr_data_gray, gray_value,
                              busy, frame_done, frame_err}, 0);
        rst = 1'b0;
        tick();
        chk("reset_state", dbg_state, 2'd0);

        // capture low for two frames: no activity at all
        base = obs_q.size();
        b0 = busy_cnt;
        send_frame(3, 2, 1, 1'b0, -1, -1);
        send_frame(3, 2, 1, 1'b0, -1, -1);
        chk("nocap_writes", obs_q.size() - base, 0);
        chk("nocap_busy", busy_cnt - b0, 0);

        // Full frame: red, white at (1,0), odd-length line 3, wide lines, extra lines
        capture = 1'b1;
        base = obs_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        b0 = busy_cnt;
        send_frame(122, 122, 0, 1'b1, 3, -1);
        check_writes("frameA", base, 14400);
        chk("frameA_latency", (obs_q.size() > base + 120) ? obs_cyc[base + 120] - lat_drv : -1, 3);
        chk("frameA_done", done_cnt - d0, 1);
        chk("frameA_err", err_cnt - e0, 0);
        last_wr = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size() - 1] : -5;
        chk("frameA_done_timing", done_cyc, last_wr + 1);
        chk("frameA_busy_seen", (busy_cnt - b0) > 0, 1);

        // Abort after row 60: vsync rises with 61 lines captured
        base = obs_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(61, 2, 1, 1'b1, -1, -1);
        check_writes("abort", base, 122);
        chk("abort_err", err_cnt - e0, 1);
        chk("abort_done", done_cnt - d0, 0);

        // Next frame still captured; capture dropped mid-frame has no effect
        base = obs_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(120, 2, 2, 1'b1, -1, 1);
        check_writes("frameB", base, 240);
        chk("frameB_done", done_cnt - d0, 1);
        chk("frameB_err", err_cnt - e0, 0);
        chk("frameB_idle", dbg_state, 2'd0);

        // Reset in the middle of row 5
        capture = 1'b1;
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < 5; r++) send_line(r, 2, 1, 1'b0, 1'b0);
        cam_href = 1'b1;
        cam_byte_valid = 1'b1;
        cam_data = 8'h07;
        tick();
        cam_data = 8'hE0;
        tick();
        chk("pre_reset_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", {wr_en, wr_addr, wr_data_rgb, wr_data_gray, gray_value,
                                 busy, frame_done, frame_err}, 0);
        chk("midreset_state", dbg_state, 2'd0);
        cam_byte_valid = 1'b0;
        cam_href = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        base = obs_q.size();
        b0 = busy_cnt;
        for (int r = 0; r < 3; r++) send_line(r, 2, 1, 1'b0, 1'b0);
        chk("postreset_writes", obs_q.size() - base, 0);
        chk("postreset_busy", busy_cnt - b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
